// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register: control word plus datapath values.
// Ports: clk, rst (sync, active-high), StallE (hold), FlushE (bubble),
//   <field>D inputs from decode, registered <field>E outputs to execute.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic [1:0]                ResultSrcD,
    input  logic                      MemWriteD,
    input  logic                      ALUsrcD,
    input  logic                      BranchD,
    input  logic                      JumpD,
    input  logic [2:0]                R_sizeD,
    input  logic [2:0]                DMem_sizeD,
    input  logic [3:0]                ALUControlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      ValidE,
    output logic                      RegWriteE,
    output logic [1:0]                ResultSrcE,
    output logic                      MemWriteE,
    output logic                      ALUsrcE,
    output logic                      BranchE,
    output logic                      JumpE,
    output logic [2:0]                R_sizeE,
    output logic [2:0]                DMem_sizeE,
    output logic [3:0]                ALUControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE
);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic [1:0]                result_src;
        logic                      mem_write;
        logic                      alu_src;
        logic                      branch;
        logic                      jump;
        logic [2:0]                r_size;
        logic [2:0]                dmem_size;
        logic [3:0]                alu_ctrl;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } id_ex_t;

    id_ex_t in_w;
    id_ex_t ex_d;
    id_ex_t ex_q;

    always_comb begin
        in_w.valid      = ValidD;
        in_w.reg_write  = RegWriteD;
        in_w.result_src = ResultSrcD;
        in_w.mem_write  = MemWriteD;
        in_w.alu_src    = ALUsrcD;
        in_w.branch     = BranchD;
        in_w.jump       = JumpD;
        in_w.r_size     = R_sizeD;
        in_w.dmem_size  = DMem_sizeD;
        in_w.alu_ctrl   = ALUControlD;
        in_w.rd1        = RD1D;
        in_w.rd2        = RD2D;
        in_w.pc         = PCD;
        in_w.imm        = ImmExtD;
        in_w.pc_plus4   = PCPlus4D;
        in_w.rs1        = Rs1D;
        in_w.rs2        = Rs2D;
        in_w.rd         = RdD;
    end

    // Flush beats stall: an all-zero slot is a bubble with no side effects.
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (!StallE) begin
            ex_d = in_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign ALUsrcE     = ex_q.alu_src;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign R_sizeE     = ex_q.r_size;
    assign DMem_sizeE  = ex_q.dmem_size;
    assign ALUControlE = ex_q.alu_ctrl;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign ImmExtE     = ex_q.imm;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;

endmodule
